// File: rtl/instr_encode_loader.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encode_loader
//  Purpose  : Packs decoded instruction fields {opcode, src1, src2, dest}
//             into 16-bit words and streams them into instruction memory at
//             consecutive (wrapping) addresses. One word per cycle, one cycle
//             of latency from handshake to memory write.
//  Options  : INSTR_LOADER_OPCODE_CHECK_EN - drop words whose opcode exceeds
//             MAX_OPCODE and raise the sticky o_err flag.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_encode_loader #(
  parameter int ADDR_W     = 8,
  parameter int MAX_OPCODE = 9
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_length,
  input  logic              i_abort,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [3:0]        i_opcode,
  input  logic [3:0]        i_srcadd_1,
  input  logic [3:0]        i_srcadd_2,
  input  logic [3:0]        i_destadd,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [15:0]       o_wdata,
  output logic              o_busy,
  output logic              o_done,
`ifdef INSTR_LOADER_OPCODE_CHECK_EN
  output logic              o_err,
`endif
  output logic [ADDR_W:0]   o_count
);

  localparam logic [ADDR_W:0]   c_one_cnt  = 1;
  localparam logic [ADDR_W-1:0] c_one_addr = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     rem_q;
  logic [ADDR_W:0]     count_q;
  logic                we_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [15:0]         wdata_q;
  logic                done_q;

  logic                w_start_acc;
  logic                w_xfer;
  logic                w_op_ok;

  assign w_start_acc = (state_q == S_IDLE) && i_start;
  // An abort in the same cycle as a valid word discards that word.
  assign w_xfer      = (state_q == S_LOAD) && i_valid && !i_abort;

`ifdef INSTR_LOADER_OPCODE_CHECK_EN
  logic err_q;

  assign w_op_ok = ({28'd0, i_opcode} <= 32'(MAX_OPCODE));
  assign o_err   = err_q;

  // Sticky illegal-opcode flag, cleared only by reset or a new load.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      err_q <= 1'b0;
    end else if (w_start_acc) begin
      err_q <= 1'b0;
    end else if (w_xfer && !w_op_ok) begin
      err_q <= 1'b1;
    end
  end
`else
  logic w_unused_max_opcode;

  assign w_op_ok             = 1'b1;
  assign w_unused_max_opcode = ^32'(MAX_OPCODE);
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; a zero-length load skips LOAD.
  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_busy  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = (i_length == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        o_ready = 1'b1;
        o_busy  = 1'b1;
        if (i_abort) begin
          state_d = S_IDLE;
        end else if (w_xfer && (rem_q == c_one_cnt)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath: latch the load, register the write port, track progress.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      addr_q  <= '0;
      rem_q   <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      we_q   <= w_xfer && w_op_ok;
      // The completion pulse trails DONE so it follows the final write.
      done_q <= (state_q == S_DONE);
      if (w_start_acc) begin
        addr_q  <= i_base_addr;
        rem_q   <= i_length;
        count_q <= '0;
      end
      if (w_xfer) begin
        rem_q <= rem_q - c_one_cnt;
        if (w_op_ok) begin
          waddr_q <= addr_q;
          wdata_q <= {i_opcode, i_srcadd_1, i_srcadd_2, i_destadd};
          addr_q  <= addr_q + c_one_addr;
          count_q <= count_q + c_one_cnt;
        end
      end
    end
  end

  assign o_we    = we_q;
  assign o_waddr = waddr_q;
  assign o_wdata = wdata_q;
  assign o_done  = done_q;
  assign o_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encode_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_encode_loader
//  Purpose  : Directed bench for instr_encode_loader. A monitor logs every
//             memory write and done pulse with a cycle stamp; each scenario
//             task drives a load and compares the log with hand-computed
//             values. Build with INSTR_LOADER_OPCODE_CHECK_EN to also cover
//             the illegal-opcode path.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encode_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              i_reset, i_start, i_abort, i_valid;
  logic [ADDR_W-1:0] i_base_addr;
  logic [ADDR_W:0]   i_length;
  logic [3:0]        i_opcode, i_srcadd_1, i_srcadd_2, i_destadd;
  logic              o_ready, o_we, o_busy, o_done;
  logic [ADDR_W-1:0] o_waddr;
  logic [15:0]       o_wdata;
  logic [ADDR_W:0]   o_count;
`ifdef INSTR_LOADER_OPCODE_CHECK_EN
  logic              o_err;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_encode_loader #(.ADDR_W(ADDR_W), .MAX_OPCODE(9)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
    .i_base_addr(i_base_addr), .i_length(i_length), .i_abort(i_abort),
    .i_valid(i_valid), .o_ready(o_ready), .i_opcode(i_opcode),
    .i_srcadd_1(i_srcadd_1), .i_srcadd_2(i_srcadd_2), .i_destadd(i_destadd),
    .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_busy(o_busy),
    .o_done(o_done),
`ifdef INSTR_LOADER_OPCODE_CHECK_EN
    .o_err(o_err),
`endif
    .o_count(o_count)
  );

  // Write/done log, sampled 1 ns after each rising edge.
  int          cyc = 0;
  int          nwr = 0;
  int          ndone = 0;
  int          done_cyc = -1;
  logic [7:0]  wa [16];
  logic [15:0] wd [16];
  int          wc [16];

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (o_we) begin
      if (nwr < 16) begin
        wa[nwr] = o_waddr;
        wd[nwr] = o_wdata;
        wc[nwr] = cyc;
      end
      nwr = nwr + 1;
    end
    if (o_done) begin
      ndone    = ndone + 1;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_log();
    nwr = 0; ndone = 0; done_cyc = -1;
  endtask

  // Pulse i_start for one cycle; returns at the first LOAD/DONE cycle.
  task automatic start_load(input logic [7:0] b, input logic [8:0] l);
    i_start = 1'b1; i_base_addr = b; i_length = l;
    tick();
    i_start = 1'b0;
  endtask

  // Present one field set for one cycle.
  task automatic send(input logic [15:0] w);
    {i_opcode, i_srcadd_1, i_srcadd_2, i_destadd} = w;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    tick(); tick();
    i_reset = 1'b0;
    tick();
    tests++;
    if ({o_ready, o_we, o_busy, o_done} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: got %b want 0000", {o_ready, o_we, o_busy, o_done});
    end
    tests++;
    if (o_waddr !== 8'h00 || o_wdata !== 16'h0000 || o_count !== 9'd0) begin
      fails++; $display("FAIL reset_data: got addr=%h data=%h count=%0d want 0/0/0", o_waddr, o_wdata, o_count);
    end
`ifdef INSTR_LOADER_OPCODE_CHECK_EN
    tests++;
    if (o_err !== 1'b0) begin
      fails++; $display("FAIL reset_err: got %b want 0", o_err);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int t0;
    clear_log();
    start_load(8'h10, 9'd3);
    t0 = cyc;
    tests++;
    if (o_busy !== 1'b1 || o_ready !== 1'b1 || o_count !== 9'd0) begin
      fails++; $display("FAIL b2b_load_state: got busy=%b ready=%b count=%0d want 1/1/0", o_busy, o_ready, o_count);
    end
    send(16'h1234); send(16'h2567); send(16'h389A);
    tests++;
    if (o_ready !== 1'b0) begin
      fails++; $display("FAIL b2b_ready_drop: got %b want 0", o_ready);
    end
    tick(); tick();
    tests++;
    if (nwr !== 3) begin
      fails++; $display("FAIL b2b_nwr: got %0d want 3", nwr);
    end
    for (int i = 0; i < 3; i++) begin
      logic [15:0] exp_d [3];
      exp_d[0] = 16'h1234; exp_d[1] = 16'h2567; exp_d[2] = 16'h389A;
      tests++;
      if (wa[i] !== 8'(8'h10 + i) || wd[i] !== exp_d[i] || wc[i] !== t0 + 1 + i) begin
        fails++; $display("FAIL b2b_write%0d: got %h@%h cyc %0d want %h@%h cyc %0d",
                          i, wd[i], wa[i], wc[i], exp_d[i], 8'(8'h10 + i), t0 + 1 + i);
      end
    end
    tests++;
    if (ndone !== 1 || done_cyc !== t0 + 4) begin
      fails++; $display("FAIL b2b_done: got n=%0d cyc=%0d want n=1 cyc=%0d", ndone, done_cyc, t0 + 4);
    end
    tests++;
    if (o_count !== 9'd3 || o_busy !== 1'b0) begin
      fails++; $display("FAIL b2b_count: got count=%0d busy=%b want 3/0", o_count, o_busy);
    end
    tests++;
    if (o_waddr !== 8'h12 || o_wdata !== 16'h389A) begin
      fails++; $display("FAIL b2b_hold: got %h@%h want 389a@12", o_wdata, o_waddr);
    end
  endtask

  task automatic test_wrap();
    clear_log();
    start_load(8'hFE, 9'd4);
    send(16'h1111); send(16'h2222); send(16'h3333); send(16'h4444);
    tick(); tick();
    tests++;
    if (nwr !== 4) begin
      fails++; $display("FAIL wrap_nwr: got %0d want 4", nwr);
    end
    tests++;
    if (wa[0] !== 8'hFE || wa[1] !== 8'hFF || wa[2] !== 8'h00 || wa[3] !== 8'h01) begin
      fails++; $display("FAIL wrap_addr: got %h %h %h %h want fe ff 00 01", wa[0], wa[1], wa[2], wa[3]);
    end
    tests++;
    if (wd[3] !== 16'h4444 || o_count !== 9'd4 || ndone !== 1) begin
      fails++; $display("FAIL wrap_end: got data=%h count=%0d done=%0d want 4444/4/1", wd[3], o_count, ndone);
    end
  endtask

  task automatic test_length_zero();
    int t0;
    clear_log();
    start_load(8'h40, 9'd0);
    t0 = cyc;
    tests++;
    if (o_busy !== 1'b0 || o_ready !== 1'b0) begin
      fails++; $display("FAIL len0_state: got busy=%b ready=%b want 0/0", o_busy, o_ready);
    end
    tick(); tick(); tick();
    tests++;
    if (ndone !== 1 || done_cyc !== t0 + 1) begin
      fails++; $display("FAIL len0_done: got n=%0d cyc=%0d want n=1 cyc=%0d", ndone, done_cyc, t0 + 1);
    end
    tests++;
    if (nwr !== 0 || o_count !== 9'd0) begin
      fails++; $display("FAIL len0_writes: got nwr=%0d count=%0d want 0/0", nwr, o_count);
    end
  endtask

  // Two-cycle gaps between words; a stray i_start mid-load must be ignored.
  task automatic test_valid_gaps();
    int t0;
    clear_log();
    start_load(8'h80, 9'd2);
    t0 = cyc;
    send(16'h5A5A);
    i_start = 1'b1; i_base_addr = 8'h99; i_length = 9'd0;
    tick();
    i_start = 1'b0;
    tick();
    send(16'h6B6B);
    tick(); tick(); tick();
    tests++;
    if (nwr !== 2) begin
      fails++; $display("FAIL gap_nwr: got %0d want 2", nwr);
    end
    tests++;
    if (wc[0] !== t0 + 1 || wc[1] !== t0 + 4) begin
      fails++; $display("FAIL gap_timing: got %0d %0d want %0d %0d", wc[0], wc[1], t0 + 1, t0 + 4);
    end
    tests++;
    if (wa[0] !== 8'h80 || wa[1] !== 8'h81 || wd[1] !== 16'h6B6B) begin
      fails++; $display("FAIL gap_data: got %h@%h %h@%h want 5a5a@80 6b6b@81", wd[0], wa[0], wd[1], wa[1]);
    end
    tests++;
    if (ndone !== 1 || done_cyc !== t0 + 5 || o_count !== 9'd2) begin
      fails++; $display("FAIL gap_done: got n=%0d cyc=%0d count=%0d want 1/%0d/2", ndone, done_cyc, o_count, t0 + 5);
    end
  endtask

  task automatic test_abort();
    clear_log();
    start_load(8'h20, 9'd5);
    send(16'h1111);
    {i_opcode, i_srcadd_1, i_srcadd_2, i_destadd} = 16'h2222;
    i_valid = 1'b1; i_abort = 1'b1;
    tick();
    i_valid = 1'b0; i_abort = 1'b0;
    tests++;
    if (o_busy !== 1'b0 || o_ready !== 1'b0) begin
      fails++; $display("FAIL abort_state: got busy=%b ready=%b want 0/0", o_busy, o_ready);
    end
    tick(); tick(); tick();
    tests++;
    if (nwr !== 1 || wa[0] !== 8'h20 || wd[0] !== 16'h1111) begin
      fails++; $display("FAIL abort_writes: got n=%0d %h@%h want 1 1111@20", nwr, wd[0], wa[0]);
    end
    tests++;
    if (ndone !== 0 || o_count !== 9'd1) begin
      fails++; $display("FAIL abort_done: got done=%0d count=%0d want 0/1", ndone, o_count);
    end
    start_load(8'h30, 9'd1);
    tests++;
    if (o_busy !== 1'b1) begin
      fails++; $display("FAIL abort_restart: got busy=%b want 1", o_busy);
    end
    send(16'h5678);
    tick(); tick();
    tests++;
    if (nwr !== 2 || wa[1] !== 8'h30 || wd[1] !== 16'h5678 || ndone !== 1 || o_count !== 9'd1) begin
      fails++; $display("FAIL abort_reload: got n=%0d %h@%h done=%0d count=%0d want 2 5678@30 1 1",
                        nwr, wd[1], wa[1], ndone, o_count);
    end
  endtask

  // Reset during LOAD kills the load and the write it would have produced.
  task automatic test_reset_midload();
    clear_log();
    start_load(8'h70, 9'd3);
    send(16'h1357);
    {i_opcode, i_srcadd_1, i_srcadd_2, i_destadd} = 16'h2468;
    i_valid = 1'b1; i_reset = 1'b1;
    tick();
    i_valid = 1'b0; i_reset = 1'b0;
    tick(); tick();
    tests++;
    if (nwr !== 1 || o_busy !== 1'b0 || o_count !== 9'd0 || ndone !== 0) begin
      fails++; $display("FAIL rst_mid: got n=%0d busy=%b count=%0d done=%0d want 1/0/0/0",
                        nwr, o_busy, o_count, ndone);
    end
  endtask

`ifdef INSTR_LOADER_OPCODE_CHECK_EN
  task automatic test_opcode_check();
    clear_log();
    start_load(8'h50, 9'd3);
    tests++;
    if (o_err !== 1'b0) begin
      fails++; $display("FAIL opc_err_clear: got %b want 0", o_err);
    end
    send(16'h1234); send(16'hC567); send(16'h289A);
    tick(); tick();
    tests++;
    if (nwr !== 2 || wa[0] !== 8'h50 || wd[0] !== 16'h1234 || wa[1] !== 8'h51 || wd[1] !== 16'h289A) begin
      fails++; $display("FAIL opc_writes: got n=%0d %h@%h %h@%h want 2 1234@50 289a@51",
                        nwr, wd[0], wa[0], wd[1], wa[1]);
    end
    tests++;
    if (o_err !== 1'b1 || ndone !== 1 || o_count !== 9'd2) begin
      fails++; $display("FAIL opc_status: got err=%b done=%0d count=%0d want 1/1/2", o_err, ndone, o_count);
    end
    start_load(8'h60, 9'd0);
    tests++;
    if (o_err !== 1'b0) begin
      fails++; $display("FAIL opc_err_restart: got %b want 0", o_err);
    end
    tick(); tick();
  endtask
`endif

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_valid = 1'b0;
    i_base_addr = '0; i_length = '0;
    i_opcode = '0; i_srcadd_1 = '0; i_srcadd_2 = '0; i_destadd = '0;
    tick();
    test_reset();
    test_back_to_back();
    test_wrap();
    test_length_zero();
    test_valid_gaps();
    test_abort();
    test_reset_midload();
`ifdef INSTR_LOADER_OPCODE_CHECK_EN
    test_opcode_check();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
